// File: rtl/branch_resolve_unit.sv
// Pipelined RV32 conditional-branch resolver: evaluates the condition, computes the target,
// checks it against the front-end prediction and keeps saturating branch/mispredict counters.
module branch_resolve_unit #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       branch_op,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pred_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic [XLEN-1:0]  target,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             illegal_op,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);

    typedef enum logic [2:0] {
        OP_BEQ  = 3'b000,
        OP_BNE  = 3'b001,
        OP_RSV2 = 3'b010,
        OP_RSV3 = 3'b011,
        OP_BLT  = 3'b100,
        OP_BGE  = 3'b101,
        OP_BLTU = 3'b110,
        OP_BGEU = 3'b111
    } br_op_e;

    br_op_e          op;
    logic            c_taken;
    logic            c_illegal;
    logic [XLEN-1:0] c_target;
    logic [XLEN-1:0] c_pc4;

    assign op       = br_op_e'(branch_op);
    assign c_target = pc + imm;
    assign c_pc4    = pc + XLEN'(4);

    always_comb begin
        c_taken   = 1'b0;
        c_illegal = 1'b0;
        case (op)
            OP_BEQ:  c_taken = (rs1 == rs2);
            OP_BNE:  c_taken = (rs1 != rs2);
            OP_BLT:  c_taken = ($signed(rs1) <  $signed(rs2));
            OP_BGE:  c_taken = ($signed(rs1) >= $signed(rs2));
            OP_BLTU: c_taken = (rs1 <  rs2);
            OP_BGEU: c_taken = (rs1 >= rs2);
            default: c_illegal = 1'b1;
        endcase
    end

    // Signals feeding the final (output) register, from inputs or from stage 1
    logic            st_valid;
    logic            st_taken;
    logic            st_illegal;
    logic [XLEN-1:0] st_target;
    logic [XLEN-1:0] st_pc4;
    logic            st_pt;
    logic [XLEN-1:0] st_ptgt;
    logic            st_mp;
    logic [XLEN-1:0] st_redirect;

    logic            res_valid;
    logic            res_taken;
    logic            res_illegal;
    logic            res_mp;
    logic [XLEN-1:0] res_target;
    logic [XLEN-1:0] res_redirect;
    logic            res_ready;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mp_cnt;

    assign res_ready   = !res_valid || out_ready;
    assign st_mp       = (st_taken != st_pt) || (st_taken && st_pt && (st_target != st_ptgt));
    assign st_redirect = st_taken ? st_target : st_pc4;

    if (STAGES == 1) begin : g_one
        assign st_valid   = in_valid;
        assign st_taken   = c_taken;
        assign st_illegal = c_illegal;
        assign st_target  = c_target;
        assign st_pc4     = c_pc4;
        assign st_pt      = pred_taken;
        assign st_ptgt    = pred_target;
        assign in_ready   = res_ready;
    end else begin : g_two
        logic            s1_valid;
        logic            s1_taken;
        logic            s1_illegal;
        logic [XLEN-1:0] s1_target;
        logic [XLEN-1:0] s1_pc4;
        logic            s1_pt;
        logic [XLEN-1:0] s1_ptgt;
        logic            s1_ready;

        assign s1_ready = !s1_valid || res_ready;
        assign in_ready = s1_ready;

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_valid   <= 1'b0;
                s1_taken   <= 1'b0;
                s1_illegal <= 1'b0;
                s1_target  <= '0;
                s1_pc4     <= '0;
                s1_pt      <= 1'b0;
                s1_ptgt    <= '0;
            end else begin
                if (flush)
                    s1_valid <= 1'b0;
                else if (s1_ready)
                    s1_valid <= in_valid;
                if (s1_ready && in_valid && !flush) begin
                    s1_taken   <= c_taken;
                    s1_illegal <= c_illegal;
                    s1_target  <= c_target;
                    s1_pc4     <= c_pc4;
                    s1_pt      <= pred_taken;
                    s1_ptgt    <= pred_target;
                end
            end
        end

        assign st_valid   = s1_valid;
        assign st_taken   = s1_taken;
        assign st_illegal = s1_illegal;
        assign st_target  = s1_target;
        assign st_pc4     = s1_pc4;
        assign st_pt      = s1_pt;
        assign st_ptgt    = s1_ptgt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid    <= 1'b0;
            res_taken    <= 1'b0;
            res_illegal  <= 1'b0;
            res_mp       <= 1'b0;
            res_target   <= '0;
            res_redirect <= '0;
        end else begin
            if (flush)
                res_valid <= 1'b0;
            else if (res_ready)
                res_valid <= st_valid;
            // Data only moves on a real load, so a stalled result stays put
            if (res_ready && st_valid && !flush) begin
                res_taken    <= st_taken;
                res_illegal  <= st_illegal;
                res_mp       <= st_mp;
                res_target   <= st_target;
                res_redirect <= st_redirect;
            end
        end
    end

    // A result handshaken in a flush cycle has left the unit, so it still counts
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt <= '0;
            mp_cnt <= '0;
        end else if (res_valid && out_ready) begin
            if (br_cnt != '1)
                br_cnt <= br_cnt + CNT_W'(1);
            if (res_mp && (mp_cnt != '1))
                mp_cnt <= mp_cnt + CNT_W'(1);
        end
    end

    assign out_valid   = res_valid;
    assign taken       = res_taken;
    assign target      = res_target;
    assign mispredict  = res_mp;
    assign redirect_pc = res_redirect;
    assign illegal_op  = res_illegal;
    assign br_count    = br_cnt;
    assign mp_count    = mp_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a 2-stage default instance plus a
// 1-stage instance with 4-bit counters sharing the request stream.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst, rst_s, flush, in_valid, out_ready, pred_taken;
    logic [2:0]  branch_op;
    logic [31:0] pc, imm, rs1, rs2, pred_target;

    logic        in_ready, out_valid, taken, mispredict, illegal_op;
    logic [31:0] target, redirect_pc;
    logic [15:0] br_count, mp_count;

    logic        s_in_ready, s_out_valid, s_taken, s_mispredict, s_illegal_op;
    logic [31:0] s_target, s_redirect_pc;
    logic [3:0]  s_br_count, s_mp_count;

    int passed = 0;
    int total  = 0;
    int exp_br = 0;
    int exp_mp = 0;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .branch_op(branch_op), .pc(pc), .imm(imm), .rs1(rs1), .rs2(rs2),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .out_valid(out_valid), .out_ready(out_ready), .taken(taken), .target(target),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .illegal_op(illegal_op),
        .br_count(br_count), .mp_count(mp_count)
    );

    branch_resolve_unit #(.XLEN(32), .STAGES(1), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst_s), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .branch_op(branch_op), .pc(pc), .imm(imm), .rs1(rs1), .rs2(rs2),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .out_valid(s_out_valid), .out_ready(out_ready), .taken(s_taken), .target(s_target),
        .mispredict(s_mispredict), .redirect_pc(s_redirect_pc), .illegal_op(s_illegal_op),
        .br_count(s_br_count), .mp_count(s_mp_count)
    );

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] p, input logic [31:0] im,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic pt, input logic [31:0] ptg);
        branch_op = op; pc = p; imm = im; rs1 = a; rs2 = b;
        pred_taken = pt; pred_target = ptg;
    endtask

    // One isolated request; 2-stage result checked after 2 edges, 1-stage after 1
    task automatic run1(input string tag, input logic [2:0] op, input logic [31:0] p,
                        input logic [31:0] im, input logic [31:0] a, input logic [31:0] b,
                        input logic pt, input logic [31:0] ptg,
                        input logic e_tk, input logic [31:0] e_tgt, input logic e_mp,
                        input logic [31:0] e_rd, input logic e_ill);
        drive(op, p, im, a, b, pt, ptg);
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_s1_valid"}, s_out_valid, 1'b1);
        chk({tag, "_s1_taken"}, s_taken, e_tk);
        chk({tag, "_s1_mp"}, s_mispredict, e_mp);
        tick();
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_taken"}, taken, e_tk);
        chk({tag, "_target"}, target, e_tgt);
        chk({tag, "_mp"}, mispredict, e_mp);
        chk({tag, "_illegal"}, illegal_op, e_ill);
        if (e_mp)
            chk({tag, "_redirect"}, redirect_pc, e_rd);
        tick();
        exp_br++;
        if (e_mp) exp_mp++;
    endtask

    initial begin
        int sent, recv, c;
        logic stalled_prev, saw_low;
        logic [31:0] held;

        rst = 1'b1; rst_s = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(3'b000, '0, '0, '0, '0, 1'b0, '0);
        tick(); tick();
        rst = 1'b0; rst_s = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_taken", taken, 1'b0);
        chk("rst_target", target, 32'h0);
        chk("rst_mp", mispredict, 1'b0);
        chk("rst_redirect", redirect_pc, 32'h0);
        chk("rst_illegal", illegal_op, 1'b0);
        chk("rst_br_count", br_count, 16'h0);
        chk("rst_mp_count", mp_count, 16'h0);
        chk("rst_in_ready", in_ready, 1'b1);

        // equal operands
        run1("eq_bge",  3'b101, 32'h1000, 32'h20, 32'h5, 32'h5, 1'b1, 32'h1020, 1'b1, 32'h1020, 1'b0, 32'h0, 1'b0);
        run1("eq_bgeu", 3'b111, 32'h1000, 32'h20, 32'h5, 32'h5, 1'b1, 32'h1020, 1'b1, 32'h1020, 1'b0, 32'h0, 1'b0);
        run1("eq_beq",  3'b000, 32'h1000, 32'h20, 32'h5, 32'h5, 1'b1, 32'h1020, 1'b1, 32'h1020, 1'b0, 32'h0, 1'b0);
        run1("eq_blt",  3'b100, 32'h1000, 32'h20, 32'h5, 32'h5, 1'b0, 32'h0,    1'b0, 32'h1020, 1'b0, 32'h0, 1'b0);
        // signed vs unsigned
        run1("sg_blt",  3'b100, 32'h2000, 32'hFFFFFFF0, 32'hFFFFFFFF, 32'h1, 1'b1, 32'h1FF0, 1'b1, 32'h1FF0, 1'b0, 32'h0, 1'b0);
        run1("sg_bltu", 3'b110, 32'h2000, 32'hFFFFFFF0, 32'hFFFFFFFF, 32'h1, 1'b1, 32'h1FF0, 1'b0, 32'h1FF0, 1'b1, 32'h2004, 1'b0);
        run1("sg_bne",  3'b001, 32'h2000, 32'hFFFFFFF0, 32'hFFFFFFFF, 32'h1, 1'b1, 32'h1234, 1'b1, 32'h1FF0, 1'b1, 32'h1FF0, 1'b0);
        run1("sg_bge",  3'b101, 32'h2000, 32'hFFFFFFF0, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0,    1'b0, 32'h1FF0, 1'b0, 32'h0, 1'b0);
        run1("sg_bgeu", 3'b111, 32'h2000, 32'hFFFFFFF0, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0,    1'b1, 32'h1FF0, 1'b1, 32'h1FF0, 1'b0);
        // address wrap
        run1("wr_beq",  3'b000, 32'hFFFFFFFC, 32'h8, 32'h0, 32'h0, 1'b1, 32'h4, 1'b1, 32'h4, 1'b0, 32'h0, 1'b0);
        run1("wr_bne",  3'b001, 32'hFFFFFFFC, 32'h8, 32'h0, 32'h0, 1'b1, 32'h4, 1'b0, 32'h4, 1'b1, 32'h0, 1'b0);
        // reserved encodings
        run1("il_op2",  3'b010, 32'h3000, 32'h40, 32'h7, 32'h7, 1'b1, 32'h3040, 1'b0, 32'h3040, 1'b1, 32'h3004, 1'b1);
        run1("il_op3",  3'b011, 32'h3000, 32'h40, 32'h7, 32'h7, 1'b0, 32'h0,    1'b0, 32'h3040, 1'b0, 32'h0, 1'b1);
        chk("dir_br_count", br_count, exp_br);
        chk("dir_mp_count", mp_count, exp_mp);

        // back-to-back stream with a 3-cycle output stall
        sent = 0; recv = 0; stalled_prev = 1'b0; saw_low = 1'b0; held = '0;
        for (c = 0; c < 40 && recv < 8; c++) begin
            in_valid = (sent < 8);
            drive(3'b000, 32'h4000 + 32'(sent) * 4, 32'h100, 32'(sent), 32'(sent),
                  1'b1, 32'h4100 + 32'(sent) * 4);
            out_ready = !(c >= 3 && c <= 5);
            #3;
            if (stalled_prev) begin
                chk("b2b_hold_valid", out_valid, 1'b1);
                chk("b2b_hold_target", target, held);
            end
            stalled_prev = out_valid && !out_ready;
            held = target;
            if (!in_ready) saw_low = 1'b1;
            if (out_valid && out_ready) begin
                chk("b2b_order", target, 32'h4100 + 32'(recv) * 4);
                recv++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("b2b_received", recv, 8);
        chk("b2b_in_ready_dropped", saw_low, 1'b1);
        tick();
        chk("b2b_no_dup", out_valid, 1'b0);
        exp_br += 8;
        chk("b2b_br_count", br_count, exp_br);
        chk("b2b_mp_count", mp_count, exp_mp);

        // flush with two in flight, a new request offered and the oldest handshaking
        out_ready = 1'b0;
        drive(3'b000, 32'h5000, 32'h10, 32'h0, 32'h0, 1'b1, 32'h5010);
        in_valid = 1'b1;
        tick();
        drive(3'b001, 32'h5100, 32'h10, 32'h0, 32'h1, 1'b0, 32'h0);
        tick();
        drive(3'b001, 32'h5200, 32'h10, 32'h0, 32'h1, 1'b0, 32'h0);
        out_ready = 1'b1;
        flush = 1'b1;
        #1;
        chk("fl_in_ready", in_ready, 1'b1);
        chk("fl_head_valid", out_valid, 1'b1);
        chk("fl_head_target", target, 32'h5010);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        exp_br++;
        for (int i = 0; i < 3; i++) begin
            chk("fl_no_out", out_valid, 1'b0);
            tick();
        end
        chk("fl_br_count", br_count, exp_br);
        chk("fl_mp_count", mp_count, exp_mp);

        // counter saturation on the 4-bit instance
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;
        chk("sat_rst_br", s_br_count, 4'h0);
        chk("sat_rst_mp", s_mp_count, 4'h0);
        out_ready = 1'b1;
        drive(3'b000, 32'h6000, 32'h10, 32'h0, 32'h1, 1'b1, 32'h6010);
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        exp_br += 20;
        exp_mp += 20;
        chk("sat_br", s_br_count, 4'hF);
        chk("sat_mp", s_mp_count, 4'hF);
        chk("wide_br", br_count, exp_br);
        chk("wide_mp", mp_count, exp_mp);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("end_rst_br", br_count, 16'h0);
        chk("end_rst_mp", mp_count, 16'h0);
        chk("end_rst_valid", out_valid, 1'b0);
        chk("end_rst_target", target, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
